// File: rtl/parallel_addsub_4bit_pkg.sv
// Shared constants for the parallel adder/subtractor: default width and mode encodings.
package parallel_addsub_4bit_pkg;

    localparam int unsigned WIDTH_DEFAULT = 4;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/parallel_addsub_4bit_full_adder.sv
// Single-bit full adder used as one stage of the ripple chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/parallel_addsub_4bit.sv
// Registered ripple-carry add/subtract with one-cycle latency.
// Optional signed-overflow output enabled by defining PARALLEL_ADDSUB_OVF_EN.
module parallel_addsub_4bit
    import parallel_addsub_4bit_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A1,
    input  logic [WIDTH-1:0] B1,
    input  logic             C,
    input  logic             in_valid,
    output logic [WIDTH-1:0] S2,
    output logic             Carry,
    output logic             Zero,
`ifdef PARALLEL_ADDSUB_OVF_EN
    output logic             Ovf,
`endif
    output logic             out_valid
);

    logic             w_sub;
    logic [WIDTH-1:0] w_b_x;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH:0]   w_carry;

    logic [WIDTH-1:0] r_s2;
    logic             r_carry;
    logic             r_zero;
    logic             r_out_valid;

    // Subtraction is A + ~B + 1: invert B and feed the mode bit in as carry-in.
    assign w_sub      = (C == MODE_SUB);
    assign w_b_x      = B1 ^ {WIDTH{w_sub}};
    assign w_carry[0] = w_sub;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_stage
        full_adder u_fa (
            .a    (A1[gi]),
            .b    (w_b_x[gi]),
            .cin  (w_carry[gi]),
            .sum  (w_sum[gi]),
            .cout (w_carry[gi+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2        <= '0;
            r_carry     <= 1'b0;
            r_zero      <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_s2    <= w_sum;
                r_carry <= w_carry[WIDTH];
                r_zero  <= (w_sum == '0);
            end
        end
    end

`ifdef PARALLEL_ADDSUB_OVF_EN
    logic r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (in_valid) begin
            r_ovf <= w_carry[WIDTH] ^ w_carry[WIDTH-1];
        end
    end

    assign Ovf = r_ovf;
`endif

    assign S2        = r_s2;
    assign Carry     = r_carry;
    assign Zero      = r_zero;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_parallel_addsub_4bit.sv
// Directed self-checking bench for parallel_addsub_4bit (Ovf checks follow PARALLEL_ADDSUB_OVF_EN).
module tb_parallel_addsub_4bit;

    logic       clk;
    logic       rst;
    logic [3:0] A1;
    logic [3:0] B1;
    logic       C;
    logic       in_valid;
    logic [3:0] S2;
    logic       Carry;
    logic       Zero;
    logic       out_valid;
`ifdef PARALLEL_ADDSUB_OVF_EN
    logic       Ovf;
`endif

    int n_cmp;
    int n_bad;

    parallel_addsub_4bit #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .A1        (A1),
        .B1        (B1),
        .C         (C),
        .in_valid  (in_valid),
        .S2        (S2),
        .Carry     (Carry),
        .Zero      (Zero),
`ifdef PARALLEL_ADDSUB_OVF_EN
        .Ovf       (Ovf),
`endif
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic c, input logic v);
        A1 = a; B1 = b; C = c; in_valid = v;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(4'b1010, 4'b0101, 1'b0, 1'b1);
        step();
        step();
        n_cmp++; if (S2 !== 4'b0000) begin n_bad++; $display("FAIL reset_s2 got %b want 0000", S2); end
        n_cmp++; if (Carry !== 1'b0) begin n_bad++; $display("FAIL reset_carry got %b want 0", Carry); end
        n_cmp++; if (Zero !== 1'b1) begin n_bad++; $display("FAIL reset_zero got %b want 1", Zero); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
`ifdef PARALLEL_ADDSUB_OVF_EN
        n_cmp++; if (Ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %b want 0", Ovf); end
`endif
        rst = 1'b0;
        drive(4'b0000, 4'b0000, 1'b0, 1'b0);
    endtask

    task automatic test_add();
        drive(4'b1111, 4'b0010, 1'b0, 1'b1);
        step();
        drive(4'b0000, 4'b0000, 1'b0, 1'b0);
        n_cmp++; if (S2 !== 4'b0001) begin n_bad++; $display("FAIL add_s2 got %b want 0001", S2); end
        n_cmp++; if (Carry !== 1'b1) begin n_bad++; $display("FAIL add_carry got %b want 1", Carry); end
        n_cmp++; if (Zero !== 1'b0) begin n_bad++; $display("FAIL add_zero got %b want 0", Zero); end
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL add_valid got %b want 1", out_valid); end
`ifdef PARALLEL_ADDSUB_OVF_EN
        n_cmp++; if (Ovf !== 1'b0) begin n_bad++; $display("FAIL add_ovf got %b want 0", Ovf); end
`endif
        step();
    endtask

    task automatic test_sub();
        drive(4'b1111, 4'b0010, 1'b1, 1'b1);
        step();
        n_cmp++; if (S2 !== 4'b1101) begin n_bad++; $display("FAIL sub1_s2 got %b want 1101", S2); end
        n_cmp++; if (Carry !== 1'b1) begin n_bad++; $display("FAIL sub1_carry got %b want 1", Carry); end
        drive(4'b0010, 4'b0111, 1'b1, 1'b1);
        step();
        drive(4'b0000, 4'b0000, 1'b0, 1'b0);
        n_cmp++; if (S2 !== 4'b1011) begin n_bad++; $display("FAIL sub2_s2 got %b want 1011", S2); end
        n_cmp++; if (Carry !== 1'b0) begin n_bad++; $display("FAIL sub2_carry got %b want 0", Carry); end
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL sub2_valid got %b want 1", out_valid); end
        step();
    endtask

    task automatic test_ovf_zero();
        drive(4'b0111, 4'b0010, 1'b0, 1'b1);
        step();
        n_cmp++; if (S2 !== 4'b1001) begin n_bad++; $display("FAIL ovf_s2 got %b want 1001", S2); end
        n_cmp++; if (Carry !== 1'b0) begin n_bad++; $display("FAIL ovf_carry got %b want 0", Carry); end
`ifdef PARALLEL_ADDSUB_OVF_EN
        n_cmp++; if (Ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got %b want 1", Ovf); end
`endif
        drive(4'b0011, 4'b0011, 1'b1, 1'b1);
        step();
        drive(4'b0000, 4'b0000, 1'b0, 1'b0);
        n_cmp++; if (S2 !== 4'b0000) begin n_bad++; $display("FAIL zero_s2 got %b want 0000", S2); end
        n_cmp++; if (Zero !== 1'b1) begin n_bad++; $display("FAIL zero_flag got %b want 1", Zero); end
        n_cmp++; if (Carry !== 1'b1) begin n_bad++; $display("FAIL zero_carry got %b want 1", Carry); end
`ifdef PARALLEL_ADDSUB_OVF_EN
        n_cmp++; if (Ovf !== 1'b0) begin n_bad++; $display("FAIL zero_ovf got %b want 0", Ovf); end
`endif
        step();
    endtask

    task automatic test_back_to_back();
        drive(4'b1101, 4'b1010, 1'b0, 1'b1);
        step();
        n_cmp++; if (S2 !== 4'b0111 || Carry !== 1'b1 || out_valid !== 1'b1) begin
            n_bad++; $display("FAIL stream0 got %b/%b/%b want 0111/1/1", S2, Carry, out_valid);
        end
        drive(4'b0111, 4'b0010, 1'b1, 1'b1);
        step();
        n_cmp++; if (S2 !== 4'b0101 || Carry !== 1'b1 || out_valid !== 1'b1) begin
            n_bad++; $display("FAIL stream1 got %b/%b/%b want 0101/1/1", S2, Carry, out_valid);
        end
        drive(4'b1111, 4'b0011, 1'b0, 1'b1);
        step();
        n_cmp++; if (S2 !== 4'b0010 || Carry !== 1'b1 || out_valid !== 1'b1) begin
            n_bad++; $display("FAIL stream2 got %b/%b/%b want 0010/1/1", S2, Carry, out_valid);
        end
        // Operands change while idle; outputs must not follow them.
        drive(4'b0011, 4'b0011, 1'b1, 1'b0);
        step();
        n_cmp++; if (S2 !== 4'b0010 || Carry !== 1'b1 || Zero !== 1'b0 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL hold got %b/%b/%b/%b want 0010/1/0/0", S2, Carry, Zero, out_valid);
        end
        // rst pulsed between edges must not disturb registered outputs.
        rst = 1'b1;
        #2;
        n_cmp++; if (S2 !== 4'b0010 || Zero !== 1'b0) begin
            n_bad++; $display("FAIL rst_between_edges got %b/%b want 0010/0", S2, Zero);
        end
        rst = 1'b0;
        step();
        n_cmp++; if (S2 !== 4'b0010 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL hold2 got %b/%b want 0010/0", S2, out_valid);
        end
    endtask

    task automatic test_reset_midstream();
        drive(4'b0001, 4'b0001, 1'b0, 1'b1);
        step();
        n_cmp++; if (S2 !== 4'b0010 || out_valid !== 1'b1) begin
            n_bad++; $display("FAIL pre_rst got %b/%b want 0010/1", S2, out_valid);
        end
        rst = 1'b1;
        drive(4'b0101, 4'b0001, 1'b0, 1'b1);
        step();
        n_cmp++; if (S2 !== 4'b0000 || Carry !== 1'b0 || Zero !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL rst_prio got %b/%b/%b/%b want 0000/0/1/0", S2, Carry, Zero, out_valid);
        end
        rst = 1'b0;
        drive(4'b0000, 4'b0000, 1'b0, 1'b0);
        step();
        n_cmp++; if (S2 !== 4'b0000 || Zero !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL post_rst got %b/%b/%b want 0000/1/0", S2, Zero, out_valid);
        end
        drive(4'b1000, 4'b1000, 1'b0, 1'b1);
        step();
        n_cmp++; if (S2 !== 4'b0000 || Carry !== 1'b1 || Zero !== 1'b1 || out_valid !== 1'b1) begin
            n_bad++; $display("FAIL first_op got %b/%b/%b/%b want 0000/1/1/1", S2, Carry, Zero, out_valid);
        end
`ifdef PARALLEL_ADDSUB_OVF_EN
        n_cmp++; if (Ovf !== 1'b1) begin n_bad++; $display("FAIL first_op_ovf got %b want 1", Ovf); end
`endif
        drive(4'b0000, 4'b0000, 1'b0, 1'b0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        drive(4'b0000, 4'b0000, 1'b0, 1'b0);
        test_reset();
        test_add();
        test_sub();
        test_ovf_zero();
        test_back_to_back();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/parallel_addsub_4bit.md
PARALLEL_ADDSUB_4BIT -- requirements
Module: parallel_addsub_4bit

Interface
REQ-001 Parameter WIDTH, default 4, operand/result width; only 4 is required to be supported and verified.
REQ-002 Port clk  input  1  rising-edge clock; the block has one clock.
REQ-003 Port rst  input  1  reset, synchronous, active-high.
REQ-004 Port A1  input  WIDTH  operand A, unsigned or two's complement.
REQ-005 Port B1  input  WIDTH  operand B.
REQ-006 Port C  input  1  mode: 0 = add (A1+B1), 1 = subtract (A1-B1).
REQ-007 Port in_valid  input  1  operands and mode are sampled on clk when high.
REQ-008 Port S2  output  WIDTH  registered sum/difference.
REQ-009 Port Carry  output  1  registered carry-out of the MSB stage.
REQ-010 Port Zero  output  1  registered; high when S2 == 0.
REQ-011 Port out_valid  output  1  high for one cycle per accepted operation.
REQ-012 Port Ovf  output  1  registered signed overflow; present only with the REQ-024 macro defined.

Function
REQ-013 Datapath SHALL be a ripple chain of WIDTH full adders with B input Bi XOR C and carry-in C, giving A1 + (B1 XOR {WIDTH{C}}) + C.
REQ-014 Add (C=0): S2 = (A1+B1) mod 16; Carry = bit 4 of the 5-bit unsigned sum.
REQ-015 Subtract (C=1): S2 = (A1-B1) mod 16; Carry = 1 when no borrow (A1 >= B1 unsigned), 0 on borrow.
REQ-016 Latency SHALL be exactly one clock: an operation sampled with in_valid=1 on edge N appears on S2/Carry/Zero/Ovf with out_valid=1 after edge N.
REQ-017 When in_valid=0 on an edge, S2/Carry/Zero/Ovf SHALL hold their previous values and out_valid SHALL be 0.
REQ-018 Back-to-back in_valid SHALL be accepted every cycle with no bubbles; C may change every cycle and takes effect per sample.
REQ-019 Zero SHALL be derived from the same registered result as S2, never from the previous result.

Reset
REQ-020 When rst=1 on a rising edge: S2=0, Carry=0, Zero=1, out_valid=0, Ovf=0.
REQ-021 rst SHALL take priority over in_valid; an operation sampled in the same edge as rst is discarded.
REQ-022 The first operation SHALL be accepted on the first edge with rst=0 and in_valid=1.
REQ-023 Outputs SHALL be unaffected by rst between clock edges.

Configuration
REQ-024 Macro PARALLEL_ADDSUB_OVF_EN: when defined, port Ovf exists and equals carry-into-MSB XOR carry-out-of-MSB, registered per REQ-016/017/020; when undefined, port Ovf and its logic are absent and all other behaviour is identical.

Structure
REQ-025 A shared package SHALL hold the WIDTH default and mode constants MODE_ADD=1'b0 and MODE_SUB=1'b1.
REQ-026 One sub-module, full_adder (a, b, cin -> sum, cout), SHALL be instantiated WIDTH times via generate; no other sub-modules.

Verification
REQ-027 rst=1 for 2 cycles -> S2=0000, Carry=0, Zero=1, out_valid=0.
REQ-028 Add: A1=1111, B1=0010, C=0 -> one cycle later S2=0001, Carry=1, Zero=0, Ovf=0.
REQ-029 Subtract: A1=1111, B1=0010, C=1 -> S2=1101, Carry=1; A1=0010, B1=0111, C=1 -> S2=1011, Carry=0.
REQ-030 Overflow/zero: A1=0111, B1=0010, C=0 -> S2=1001, Ovf=1; A1=0011, B1=0011, C=1 -> S2=0000, Zero=1, Carry=1.
REQ-031 Streaming with C toggling each cycle over pairs (1101,1010), (0111,0010), (1111,0011) -> results 0111/C1, 0101/C1, 0010/C1 on consecutive cycles; then in_valid=0 -> outputs hold and out_valid=0.
REQ-032 Assert rst during a valid stream -> next cycle outputs equal the REQ-020 reset values and the in-flight result is dropped.
